sfr_arb: RTL and testbench
==========================

# sfr_arb

Round-robin arbiter that shares the single tile SFR slave port among up to four bus masters, such as the core data port and the debug/UDM port, on the MemSplit32 protocol. It sits in the tile between the masters and the SFR block. It grants one master per cycle and routes read responses back to the owning master. It also enforces a single outstanding read, with a timeout so a lost response cannot hang the bus.

## Interface
Parameters:
- NUM_MST, 2, number of masters (2..4)
- RESP_TIMEOUT, 15, cycles to wait for a read response before returning an error response (1..255)
- ERR_RDATA, 32'hDEADDEAD, rdata returned on timeout

Ports:
- clk_i  in  1  clock; the block has one clock, all logic on its rising edge
- rst_i  in  1  reset, synchronous, active-high
- m_req_i  in  NUM_MST  per-master request
- m_we_i  in  NUM_MST  per-master write enable
- m_addr_bi  in  NUM_MST*32  per-master address, master k at [32k+31:32k]
- m_be_bi  in  NUM_MST*4  per-master byte enables
- m_wdata_bi  in  NUM_MST*32  per-master write data
- m_ack_o  out  NUM_MST  per-master request accepted (combinational)
- m_resp_o  out  NUM_MST  per-master read response valid
- m_rdata_bo  out  NUM_MST*32  per-master read data
- s_req_o, s_we_o  out  1  slave request / write enable
- s_addr_bo  out  32  slave address
- s_be_bo  out  4  slave byte enables
- s_wdata_bo  out  32  slave write data
- s_ack_i  in  1  slave accept
- s_resp_i  in  1  slave read response valid
- s_rdata_bi  in  32  slave read data
- timeout_o  out  1  one-cycle pulse on response timeout

## Operation
- State machine with two states.
  - IDLE: arbitration enabled.
  - WAIT_RESP: read outstanding. Owner index `own` and timeout counter `tcnt` are registered.
- Arbitration in IDLE is combinational.
  - `gnt` is the first requesting master found scanning from priority pointer `ptr` upward, modulo NUM_MST.
  - The slave outputs mux master `gnt`'s fields. `s_req_o = |m_req_i`.
  - `m_ack_o[gnt] = s_ack_i`. All other `m_ack_o` bits are 0.
- Accept means `s_req_o & s_ack_i` in IDLE. On accept:
  - `ptr <= gnt+1` mod NUM_MST.
  - If `!we`: go to WAIT_RESP, set `own <= gnt`, set `tcnt <= 0`.
  - If `we`: stay in IDLE, so a new write can be accepted every cycle.
- WAIT_RESP:
  - `s_req_o = 0`, all `m_ack_o = 0`.
  - If `s_resp_i`: `m_resp_o[own] = 1` and `m_rdata_bo[own] = s_rdata_bi`, both combinational, then go to IDLE.
  - Else if `tcnt == RESP_TIMEOUT-1`: go to IDLE. In the next cycle, registered, `m_resp_o[own] = 1`, `m_rdata_bo[own] = ERR_RDATA`, `timeout_o = 1`.
  - Else `tcnt <= tcnt+1`.
- `s_resp_i` arriving in IDLE, whether stale or after a timeout, is dropped: no `m_resp_o` is asserted.
- `m_rdata_bo` for non-owners and outside response cycles is 0.
- Reset (rst_i high at a clock edge):
  - state is IDLE, `ptr` = 0, `own` = 0, `tcnt` = 0.
  - The pending timeout response is cancelled.
  - A read in flight is abandoned with no response delivered.
- Output values while rst_i is high:
  - `s_req_o` is 0.
  - All `m_ack_o` and `m_resp_o` bits are 0.
  - `timeout_o` is 0.
  - Slave data outputs are don't-care but deterministic; they mux master `ptr`.

## Timing
- Grant to slave: 0 cycles, a combinational path from `m_req_i` to `s_req_o`.
- Read with a 1-cycle slave, e.g. the SFR:
  - req and ack in cycle N, resp forwarded in N+1.
  - Next accept possible in N+2.
- Write throughput: 1 per cycle. Masters rotate each accepted cycle when all are requesting.
- Timeout: read accepted in N with no `s_resp_i` → `m_resp_o[own]` and `timeout_o` high in cycle N+RESP_TIMEOUT+1.
- A master holds req, we, addr, be and wdata stable until `m_ack_o` is seen.

## Test plan
- Single read from master 0, SFR-like slave returning 32'h12345678 one cycle after ack → `m_resp_o[0] = 1` in N+1 with rdata 32'h12345678; `m_resp_o[1] = 0`.
- Masters 0 and 1 both issue continuous writes from reset → acks alternate 0,1,0,1 on consecutive cycles; slave sees 4 writes in 4 cycles with matching addresses.
- Master 1 reads while master 0 requests in the next cycle → master 0's `m_ack_o` stays 0 until the response cycle has passed; master 0 is accepted in N+2.
- Slave never responds, RESP_TIMEOUT=15, read accepted in cycle 10 → `m_resp_o[own]`, rdata 32'hDEADDEAD and `timeout_o` all high exactly in cycle 26; next request accepted in cycle 26.
- rst_i asserted during WAIT_RESP, then a late `s_resp_i` → no `m_resp_o` pulse; after reset, master 0 wins a simultaneous 0/1 request.
- NUM_MST=4, masters 1 and 3 requesting with `ptr` = 2 → master 3 granted first, then master 1.

Source files
------------

// File: rtl/sfr_arb.sv
// sfr_arb: round-robin arbiter sharing one SFR slave port among up to four MemSplit32 masters
module sfr_arb #(
    parameter int          NUM_MST      = 2,
    parameter int          RESP_TIMEOUT = 15,
    parameter logic [31:0] ERR_RDATA    = 32'hDEADDEAD
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_MST-1:0]    m_req_i,
    input  logic [NUM_MST-1:0]    m_we_i,
    input  logic [NUM_MST*32-1:0] m_addr_bi,
    input  logic [NUM_MST*4-1:0]  m_be_bi,
    input  logic [NUM_MST*32-1:0] m_wdata_bi,
    output logic [NUM_MST-1:0]    m_ack_o,
    output logic [NUM_MST-1:0]    m_resp_o,
    output logic [NUM_MST*32-1:0] m_rdata_bo,
    output logic                  s_req_o,
    output logic                  s_we_o,
    output logic [31:0]           s_addr_bo,
    output logic [3:0]            s_be_bo,
    output logic [31:0]           s_wdata_bo,
    input  logic                  s_ack_i,
    input  logic                  s_resp_i,
    input  logic [31:0]           s_rdata_bi,
    output logic                  timeout_o
);
    localparam int PW = $clog2(NUM_MST);
    typedef enum logic {IDLE, WAIT_RESP} state_t;
    state_t        r_state, w_next;
    logic [PW-1:0] r_ptr, r_own, w_gnt, w_sel, w_gnt_inc;
    logic [7:0]    r_tcnt;
    logic          r_to_pend, w_accept, w_tmo;
    assign w_accept  = (r_state == IDLE) & (|m_req_i) & s_ack_i;
    assign w_tmo     = (r_state == WAIT_RESP) & ~s_resp_i & (r_tcnt == 8'(RESP_TIMEOUT - 1));
    assign w_sel     = rst_i ? r_ptr : w_gnt;
    assign w_gnt_inc = (w_gnt == PW'(NUM_MST - 1)) ? '0 : w_gnt + PW'(1);
    assign s_we_o     = m_we_i[w_sel];
    assign s_addr_bo  = m_addr_bi[32*w_sel +: 32];
    assign s_be_bo    = m_be_bi[4*w_sel +: 4];
    assign s_wdata_bo = m_wdata_bi[32*w_sel +: 32];
    // Grant the first requester found scanning upward from the priority pointer
    always_comb begin
        w_gnt = r_ptr;
        for (int i = NUM_MST - 1; i >= 0; i--)
            if (m_req_i[(int'(r_ptr) + i) % NUM_MST]) w_gnt = PW'((int'(r_ptr) + i) % NUM_MST);
    end
    // State register
    always_ff @(posedge clk_i) r_state <= rst_i ? IDLE : w_next;
    // Reads park the arbiter until the response or the timeout; writes keep it idle
    always_comb begin
        w_next = (r_state == IDLE) ? ((w_accept & ~s_we_o) ? WAIT_RESP : IDLE)
                                   : ((s_resp_i | w_tmo) ? IDLE : WAIT_RESP);
    end
    // Priority pointer, read owner, response timer and pending timeout response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr     <= '0;
            r_own     <= '0;
            r_tcnt    <= '0;
            r_to_pend <= 1'b0;
        end else begin
            r_to_pend <= w_tmo;
            if (w_accept) r_ptr <= w_gnt_inc;
            if (w_accept & ~s_we_o) begin
                r_own  <= w_gnt;
                r_tcnt <= '0;
            end else if (r_state == WAIT_RESP) r_tcnt <= r_tcnt + 8'd1;
        end
    end
    // Handshake and response routing; everything is quiet while reset is held
    always_comb begin
        s_req_o    = 1'b0;
        m_ack_o    = '0;
        m_resp_o   = '0;
        m_rdata_bo = '0;
        timeout_o  = 1'b0;
        if (!rst_i) begin
            if (r_state == IDLE) begin
                s_req_o        = |m_req_i;
                m_ack_o[w_gnt] = s_ack_i & (|m_req_i);
            end else if (s_resp_i) begin
                m_resp_o[r_own]            = 1'b1;
                m_rdata_bo[32*r_own +: 32] = s_rdata_bi;
            end
            if (r_to_pend) begin
                m_resp_o[r_own]            = 1'b1;
                m_rdata_bo[32*r_own +: 32] = ERR_RDATA;
                timeout_o                  = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sfr_arb.sv
// tb_sfr_arb: directed and randomized checks of sfr_arb against a cycle-count reference model
module tb_sfr_arb;
    localparam int          N   = 4;
    localparam int          T   = 15;
    localparam logic [31:0] ERR = 32'hDEADDEAD;
    logic            clk = 1'b0, rst_i;
    logic [N-1:0]    m_req, m_we, m_ack, m_resp;
    logic [N*32-1:0] m_addr, m_wdata, m_rdata;
    logic [N*4-1:0]  m_be;
    logic            s_req, s_we, s_ack, s_resp, tmo;
    logic [31:0]     s_addr, s_wdata, s_rdata;
    logic [3:0]      s_be;
    sfr_arb #(.NUM_MST(N), .RESP_TIMEOUT(T), .ERR_RDATA(ERR)) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .m_req_i(m_req), .m_we_i(m_we), .m_addr_bi(m_addr), .m_be_bi(m_be), .m_wdata_bi(m_wdata),
        .m_ack_o(m_ack), .m_resp_o(m_resp), .m_rdata_bo(m_rdata),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_be_bo(s_be), .s_wdata_bo(s_wdata),
        .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata), .timeout_o(tmo)
    );
    always #5 clk = ~clk;
    int tests = 0, fails = 0, cyc = 0, n_to = 0;
    bit busy = 0, to_pend = 0;
    int own = 0, to_own = 0, ptr = 0, acc_cyc = 0;
    logic [N-1:0]    o_ack, o_resp;
    logic [N*32-1:0] o_rdata;
    logic [31:0]     o_saddr;
    logic            o_to;
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // One clock: compare all outputs against the model at negedge, advance the model, return #1 after posedge
    task automatic step();
        int g, sel;
        bit acc;
        logic [N-1:0]    e_ack, e_resp;
        logic [N*32-1:0] e_rd;
        logic            e_sreq, e_to;
        @(negedge clk);
        g = ptr;
        for (int i = N - 1; i >= 0; i--) if (m_req[(ptr + i) % N]) g = (ptr + i) % N;
        e_ack = '0; e_resp = '0; e_rd = '0; e_sreq = 0; e_to = 0;
        if (!rst_i) begin
            if (!busy) begin
                e_sreq = |m_req;
                if (e_sreq) e_ack[g] = s_ack;
            end else if (s_resp) begin
                e_resp[own] = 1'b1;
                e_rd[own*32 +: 32] = s_rdata;
            end
            if (to_pend) begin
                e_resp[to_own] = 1'b1;
                e_rd[to_own*32 +: 32] = ERR;
                e_to = 1'b1;
            end
        end
        sel = rst_i ? ptr : g;
        chk("ack", m_ack, e_ack);
        chk("resp", m_resp, e_resp);
        chk("rdata", m_rdata, e_rd);
        chk("s_req", s_req, e_sreq);
        chk("timeout", tmo, e_to);
        chk("slv_fields", {s_we, s_be, s_addr, s_wdata},
            {m_we[sel], m_be[sel*4 +: 4], m_addr[sel*32 +: 32], m_wdata[sel*32 +: 32]});
        o_ack = m_ack; o_resp = m_resp; o_rdata = m_rdata; o_saddr = s_addr; o_to = tmo;
        acc = !rst_i && !busy && (|m_req) && s_ack;
        if (rst_i) begin
            busy = 0; ptr = 0; to_pend = 0;
        end else begin
            to_pend = 0;
            if (busy) begin
                if (s_resp) busy = 0;
                else if (cyc - acc_cyc == T) begin busy = 0; to_pend = 1; to_own = own; end
            end else if (acc) begin
                ptr = (g + 1) % N;
                if (!m_we[g]) begin busy = 1; own = g; acc_cyc = cyc; end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask
    task automatic new_txn(input int i);
        m_req[i] = 1'b1;
        m_we[i] = 1'($urandom % 2);
        m_addr[i*32 +: 32] = $urandom;
        m_be[i*4 +: 4] = 4'($urandom);
        m_wdata[i*32 +: 32] = $urandom;
    endtask
    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask
    initial begin
        int hit;
        rst_i = 1'b1; m_req = '0; m_we = '0; m_be = '1; s_ack = 1'b1; s_resp = 1'b0; s_rdata = '0;
        for (int i = 0; i < N; i++) begin
            m_addr[i*32 +: 32] = 32'h100 + 32'(i) * 4;
            m_wdata[i*32 +: 32] = 32'hA0 + 32'(i);
        end
        step();
        step();
        rst_i = 1'b0;
        // single read from master 0, slave answers one cycle after ack
        m_req = 4'b0001; m_we = 4'b0000;
        step();
        chk("rd_ack", o_ack, 4'b0001);
        m_req = '0; s_resp = 1'b1; s_rdata = 32'h12345678;
        step();
        chk("rd_resp", o_resp, 4'b0001);
        chk("rd_data", o_rdata[31:0], 32'h12345678);
        s_resp = 1'b0;
        // two masters streaming writes alternate every cycle
        do_reset();
        m_req = 4'b0011; m_we = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("wr_alt", o_ack, (k % 2) ? 4'b0010 : 4'b0001);
            chk("wr_addr", o_saddr, 32'h100 + 32'(k % 2) * 4);
        end
        m_req = '0;
        // master 1 read blocks master 0 until the response cycle has passed
        m_req = 4'b0010; m_we = 4'b0001;
        step();
        chk("blk_ack1", o_ack, 4'b0010);
        m_req = 4'b0001; s_resp = 1'b1; s_rdata = 32'h0BADF00D;
        step();
        chk("blk_ack0", o_ack, 4'b0000);
        chk("blk_resp", o_resp, 4'b0010);
        s_resp = 1'b0;
        step();
        chk("blk_n2", o_ack, 4'b0001);
        m_req = '0;
        // lost response: error response and pulse exactly RESP_TIMEOUT+1 cycles after accept
        m_req = 4'b0001; m_we = 4'b0000;
        step();
        chk("to_acc", o_ack, 4'b0001);
        m_req = 4'b0010; m_we = 4'b0010;
        hit = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (o_to) begin
                hit = k;
                chk("to_resp", o_resp, 4'b0001);
                chk("to_rdata", o_rdata[31:0], ERR);
                chk("to_next_ack", o_ack, 4'b0010);
                break;
            end
        end
        chk("to_latency", 32'(hit), 32'(T + 1));
        m_req = '0; s_resp = 1'b1;
        step();
        chk("to_stale", o_resp, 4'b0000);
        s_resp = 1'b0;
        // reset while a read is outstanding drops the late response
        m_req = 4'b0001; m_we = 4'b0000;
        step();
        m_req = '0;
        step();
        do_reset();
        s_resp = 1'b1;
        step();
        chk("rst_noresp", o_resp, 4'b0000);
        s_resp = 1'b0;
        m_req = 4'b0011; m_we = 4'b0011;
        step();
        chk("rst_m0_wins", o_ack, 4'b0001);
        m_req = '0;
        // pointer at 2 with masters 1 and 3 requesting
        do_reset();
        m_req = 4'b0010; m_we = 4'b1010;
        step();
        m_req = 4'b1010;
        step();
        chk("ptr2_first", o_ack, 4'b1000);
        m_req = 4'b0010;
        step();
        chk("ptr2_second", o_ack, 4'b0010);
        m_req = '0;
        o_ack = '0;
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_req[i] && o_ack[i]) begin
                    m_req[i] = 1'b0;
                    if ($urandom % 2 == 0) new_txn(i);
                end else if (!m_req[i] && $urandom % 3 == 0) new_txn(i);
            end
            s_ack = ($urandom % 4) != 0;
            s_resp = ($urandom % 6) == 0;
            s_rdata = $urandom;
            rst_i = ($urandom % 300) == 0;
            step();
            if (o_to) n_to++;
        end
        chk("rand_timeouts_seen", 1'(n_to != 0), 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
